board_action_ctrl: RTL and testbench

Sequencer between mouse-click decoding and the board redraw pipeline. Turns left/right click requests on a board cell into validated, one-at-a-time `defuse` / `mark_flag` / `explode` commands with a stable `symbol_ind_x/y`, and drives them toward the redraw block. Keeps its own flag and defused bitmaps to reject illegal actions. Tracks game state: playing, lost, won.

---
 rtl/board_action_ctrl.sv | 244 ++++++++++++++++++++++++
 tb/tb_board_action_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_action_ctrl.sv
`default_nettype none
// ============================================================================
// board_action_ctrl
// Validates click actions on board cells and sequences one defuse / flag /
// explode command at a time toward the redraw pipeline.
// Revision: 1.0
// ============================================================================
module board_action_ctrl #(
  parameter int PULSE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                new_game,
  input  logic [1:0]          level,
  input  logic [7:0]          mine_count,
  input  logic                left_click,
  input  logic                right_click,
  input  logic [4:0]          cell_x,
  input  logic [4:0]          cell_y,
  input  logic                cell_valid,
  input  logic [7:0][7:0]     mine_arr_easy,
  input  logic [9:0][9:0]     mine_arr_medium,
  input  logic [15:0][15:0]   mine_arr_hard,
  output logic [4:0]          symbol_ind_x,
  output logic [4:0]          symbol_ind_y,
  output logic                defuse,
  output logic                mark_flag,
  output logic                explode,
  output logic                game_over,
  output logic                game_won,
  output logic                busy,
  output logic [7:0]          flags_left,
  output logic [8:0]          cells_defused
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_IDLE_PLAY = 3'd1,
    ST_CHECK     = 3'd2,
    ST_DEFUSE    = 3'd3,
    ST_FLAG      = 3'd4,
    ST_GAME_OVER = 3'd5,
    ST_WON       = 3'd6
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     level_q, level_d;
  logic [7:0]     mines_q, mines_d;
  logic           lclk_q, rclk_q;
  logic           act_right_q, act_right_d;
  logic [4:0]     cx_q, cx_d, cy_q, cy_d;
  logic [4:0]     symx_q, symx_d, symy_q, symy_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [255:0]   flag_map_q, flag_map_d;
  logic [255:0]   def_map_q, def_map_d;
  logic           explode_q, explode_d;
  logic           over_q, over_d;
  logic           won_q, won_d;
  logic [7:0]     flags_q, flags_d;
  logic [8:0]     cells_q, cells_d;

  logic [4:0]     size;
  logic [8:0]     nn;
  logic           mine_hit;
  logic [7:0]     idx;
  logic           lrise, rrise;
  logic           win;

  always_comb begin
    size     = 5'd0;
    nn       = 9'd0;
    mine_hit = 1'b0;
    case (level_q)
      2'b01: begin
        size     = 5'd8;
        nn       = 9'd64;
        mine_hit = mine_arr_easy[cy_q[2:0]][cx_q[2:0]];
      end
      2'b10: begin
        size     = 5'd10;
        nn       = 9'd100;
        mine_hit = mine_arr_medium[cy_q[3:0]][cx_q[3:0]];
      end
      2'b11: begin
        size     = 5'd16;
        nn       = 9'd256;
        mine_hit = mine_arr_hard[cy_q[3:0]][cx_q[3:0]];
      end
      default: ;
    endcase
  end

  assign idx   = {cy_q[3:0], cx_q[3:0]};
  assign lrise = left_click & ~lclk_q;
  assign rrise = right_click & ~rclk_q;
  // A mine count covering the whole board makes the target unreachable, so it wins outright.
  assign win   = ({1'b0, mines_q} >= nn) || (cells_q == (nn - {1'b0, mines_q}));

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    mines_d     = mines_q;
    act_right_d = act_right_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    symx_d      = symx_q;
    symy_d      = symy_q;
    cnt_d       = cnt_q;
    flag_map_d  = flag_map_q;
    def_map_d   = def_map_q;
    explode_d   = explode_q;
    over_d      = over_q;
    won_d       = won_q;
    flags_d     = flags_q;
    cells_d     = cells_q;

    if (new_game && (level != 2'b00)) begin
      state_d    = ST_IDLE_PLAY;
      level_d    = level;
      mines_d    = mine_count;
      flags_d    = mine_count;
      cells_d    = 9'd0;
      flag_map_d = '0;
      def_map_d  = '0;
      explode_d  = 1'b0;
      over_d     = 1'b0;
      won_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE_PLAY: begin
          if ((lrise || rrise) && cell_valid && (cell_x < size) && (cell_y < size)) begin
            act_right_d = ~lrise;
            cx_d        = cell_x;
            cy_d        = cell_y;
            state_d     = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (flag_map_q[idx] || def_map_q[idx]) begin
            state_d = ST_IDLE_PLAY;
          end else if (!act_right_q && mine_hit) begin
            symx_d    = cx_q;
            symy_d    = cy_q;
            explode_d = 1'b1;
            over_d    = 1'b1;
            state_d   = ST_GAME_OVER;
          end else if (!act_right_q) begin
            symx_d         = cx_q;
            symy_d         = cy_q;
            def_map_d[idx] = 1'b1;
            cells_d        = cells_q + 9'd1;
            cnt_d          = C_CNT_LOAD;
            state_d        = ST_DEFUSE;
          end else begin
            symx_d          = cx_q;
            symy_d          = cy_q;
            flag_map_d[idx] = 1'b1;
            flags_d         = (flags_q != 8'd0) ? flags_q - 8'd1 : 8'd0;
            cnt_d           = C_CNT_LOAD;
            state_d         = ST_FLAG;
          end
        end
        ST_DEFUSE: begin
          if (cnt_q == '0) begin
            if (win) begin
              won_d   = 1'b1;
              state_d = ST_WON;
            end else begin
              state_d = ST_IDLE_PLAY;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_FLAG: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE_PLAY;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_OFF;
      level_q     <= 2'b00;
      mines_q     <= 8'd0;
      lclk_q      <= 1'b0;
      rclk_q      <= 1'b0;
      act_right_q <= 1'b0;
      cx_q        <= 5'd0;
      cy_q        <= 5'd0;
      symx_q      <= 5'd0;
      symy_q      <= 5'd0;
      cnt_q       <= '0;
      flag_map_q  <= '0;
      def_map_q   <= '0;
      explode_q   <= 1'b0;
      over_q      <= 1'b0;
      won_q       <= 1'b0;
      flags_q     <= 8'd0;
      cells_q     <= 9'd0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      mines_q     <= mines_d;
      lclk_q      <= left_click;
      rclk_q      <= right_click;
      act_right_q <= act_right_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      symx_q      <= symx_d;
      symy_q      <= symy_d;
      cnt_q       <= cnt_d;
      flag_map_q  <= flag_map_d;
      def_map_q   <= def_map_d;
      explode_q   <= explode_d;
      over_q      <= over_d;
      won_q       <= won_d;
      flags_q     <= flags_d;
      cells_q     <= cells_d;
    end
  end

  assign symbol_ind_x  = symx_q;
  assign symbol_ind_y  = symy_q;
  assign defuse        = (state_q == ST_DEFUSE);
  assign mark_flag     = (state_q == ST_FLAG);
  assign explode       = explode_q;
  assign game_over     = over_q;
  assign game_won      = won_q;
  assign busy          = (state_q == ST_CHECK) || (state_q == ST_DEFUSE) || (state_q == ST_FLAG);
  assign flags_left    = flags_q;
  assign cells_defused = cells_q;

endmodule
`default_nettype wire

// File: tb/tb_board_action_ctrl.sv
`default_nettype none
// ============================================================================
// tb_board_action_ctrl
// Scoreboard bench: expected commands are queued as clicks are driven and
// matched against strobe / explode rising edges.
// Revision: 1.0
// ============================================================================
module tb_board_action_ctrl;

  localparam int P = 4;

  logic                clk;
  logic                rst;
  logic                new_game;
  logic [1:0]          level;
  logic [7:0]          mine_count;
  logic                left_click, right_click;
  logic [4:0]          cell_x, cell_y;
  logic                cell_valid;
  logic [7:0][7:0]     easy_map;
  logic [9:0][9:0]     med_map;
  logic [15:0][15:0]   hard_map;
  logic [4:0]          symbol_ind_x, symbol_ind_y;
  logic                defuse, mark_flag, explode, game_over, game_won, busy;
  logic [7:0]          flags_left;
  logic [8:0]          cells_defused;

  board_action_ctrl #(.PULSE_CYCLES(P)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .new_game        (new_game),
    .level           (level),
    .mine_count      (mine_count),
    .left_click      (left_click),
    .right_click     (right_click),
    .cell_x          (cell_x),
    .cell_y          (cell_y),
    .cell_valid      (cell_valid),
    .mine_arr_easy   (easy_map),
    .mine_arr_medium (med_map),
    .mine_arr_hard   (hard_map),
    .symbol_ind_x    (symbol_ind_x),
    .symbol_ind_y    (symbol_ind_y),
    .defuse          (defuse),
    .mark_flag       (mark_flag),
    .explode         (explode),
    .game_over       (game_over),
    .game_won        (game_won),
    .busy            (busy),
    .flags_left      (flags_left),
    .cells_defused   (cells_defused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  typedef struct {
    int kind;   // 1 defuse, 2 flag, 3 explode
    int x;
    int y;
    int cyc;
  } exp_t;
  exp_t sb[$];

  // Reference model of the game
  bit m_flag[256];
  bit m_def[256];
  int m_level, m_n, m_mines, m_flags_left, m_cells;
  bit m_over, m_won, m_playing;

  function automatic bit mine_at(input int x, input int y);
    case (m_level)
      1:       return easy_map[y][x];
      2:       return med_map[y][x];
      3:       return hard_map[y][x];
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: pops one expectation per command rising edge and checks pulse width
  bit prev_def = 0, prev_flg = 0, prev_exp = 0;
  int plen = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_def = 0; prev_flg = 0; prev_exp = 0; plen = 0;
    end else begin
      if ((defuse && !prev_def) || (mark_flag && !prev_flg) || (explode && !prev_exp)) begin
        automatic int kobs = defuse ? 1 : (mark_flag ? 2 : 3);
        if (sb.size() == 0) begin
          chk("unexpected_cmd", kobs, 0);
        end else begin
          automatic exp_t e = sb.pop_front();
          chk("cmd_kind", kobs, e.kind);
          chk("sym_x", symbol_ind_x, e.x);
          chk("sym_y", symbol_ind_y, e.y);
          chk("cmd_latency", cyc, e.cyc);
        end
      end
      if (defuse || mark_flag) plen++;
      else if (plen != 0) begin
        chk("pulse_len", plen, P);
        plen = 0;
      end
      prev_def = defuse; prev_flg = mark_flag; prev_exp = explode;
    end
  end

  task automatic start_game(input int lvl, input int mc);
    @(posedge clk); #1;
    new_game = 1'b1; level = 2'(lvl); mine_count = 8'(mc);
    @(posedge clk); #1;
    new_game = 1'b0;
    if (lvl != 0) begin
      m_level = lvl;
      m_n = (lvl == 1) ? 8 : ((lvl == 2) ? 10 : 16);
      m_mines = mc; m_flags_left = mc; m_cells = 0;
      m_over = 0; m_won = 0; m_playing = 1;
      for (int i = 0; i < 256; i++) begin m_flag[i] = 0; m_def[i] = 0; end
    end
  endtask

  task automatic do_click(input bit l, input bit r, input int x, input int y,
                          input bit v, input bit busy_now, input bit timed);
    bit acc;
    int kind, idx, issue, nn, n;
    acc = m_playing && !m_over && !m_won && !busy_now && v && (l || r)
          && (x < m_n) && (y < m_n);
    kind = 0;
    if (acc) begin
      idx = y * 16 + x;
      if (m_flag[idx] || m_def[idx]) kind = 0;
      else if (l && mine_at(x, y)) begin kind = 3; m_over = 1; end
      else if (l) begin
        kind = 1; m_def[idx] = 1; m_cells++;
        nn = m_n * m_n;
        if (m_mines >= nn || m_cells == nn - m_mines) m_won = 1;
      end else begin
        kind = 2; m_flag[idx] = 1;
        if (m_flags_left > 0) m_flags_left--;
      end
    end
    @(posedge clk); #1;
    left_click = l; right_click = r; cell_x = 5'(x); cell_y = 5'(y); cell_valid = v;
    issue = cyc;
    if (kind != 0) sb.push_back('{kind, x, y, issue + 2});
    @(posedge clk); #1;
    left_click = 1'b0; right_click = 1'b0;
    if (timed) begin
      @(negedge clk);
      chk("busy_after_click", busy, acc);
      n = 0;
      while (busy && n < 40) begin @(negedge clk); n++; end
      chk("idle_latency", cyc - issue, !acc ? 1 : ((kind == 1 || kind == 2) ? 2 + P : 2));
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin @(negedge clk); n++; end
    chk("settle_busy", busy, 0);
    chk("cells_defused", cells_defused, m_cells);
    chk("flags_left", flags_left, m_flags_left);
    chk("game_over", game_over, m_over);
    chk("explode", explode, m_over);
    chk("game_won", game_won, m_won);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; new_game = 1'b0; level = 2'b00; mine_count = 8'd0;
    left_click = 1'b0; right_click = 1'b0; cell_x = 5'd0; cell_y = 5'd0; cell_valid = 1'b0;
    easy_map = '0; easy_map[7][0] = 1'b1;
    med_map = '1;  med_map[4][3] = 1'b0;
    hard_map = '0;
    m_level = 0; m_n = 0; m_mines = 0; m_flags_left = 0; m_cells = 0;
    m_over = 0; m_won = 0; m_playing = 0;

    repeat (3) @(posedge clk); #1;
    chk("rst_defuse", defuse, 0);
    chk("rst_mark_flag", mark_flag, 0);
    chk("rst_explode", explode, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_game_won", game_won, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags_left", flags_left, 0);
    chk("rst_cells", cells_defused, 0);
    chk("rst_sym_x", symbol_ind_x, 0);
    chk("rst_sym_y", symbol_ind_y, 0);
    rst = 1'b0;

    // Easy board, plain defuse
    start_game(1, 10);
    settle();
    do_click(1, 0, 2, 3, 1, 0, 1);
    settle();

    // Flag, then left and right on the flagged cell
    do_click(0, 1, 5, 5, 1, 0, 1);
    settle();
    do_click(1, 0, 5, 5, 1, 0, 1);
    do_click(0, 1, 5, 5, 1, 0, 1);
    settle();

    // Simultaneous edges, click while busy, out-of-range and invalid clicks
    do_click(1, 1, 1, 1, 1, 0, 0);
    do_click(1, 0, 4, 4, 1, 1, 0);
    settle();
    do_click(1, 0, 9, 0, 1, 0, 1);
    do_click(1, 0, 3, 3, 0, 0, 1);
    settle();

    // Mine hit, then ignored click, ignored level-00 new_game
    do_click(1, 0, 0, 7, 1, 0, 1);
    settle();
    do_click(1, 0, 2, 2, 1, 0, 1);
    chk("sym_hold_x", symbol_ind_x, 0);
    chk("sym_hold_y", symbol_ind_y, 7);
    start_game(0, 5);
    settle();
    start_game(1, 10);
    settle();

    // Medium board with one safe cell
    start_game(2, 99);
    do_click(1, 0, 3, 4, 1, 0, 1);
    settle();
    do_click(0, 1, 5, 5, 1, 0, 1);
    settle();

    // Reset during the third strobe cycle
    start_game(1, 10);
    do_click(1, 0, 6, 6, 1, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_defuse", defuse, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_defuse", defuse, 0);
    chk("async_rst_cells", cells_defused, 0);
    chk("async_rst_flags", flags_left, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sym_x", symbol_ind_x, 0);
    m_playing = 0; m_cells = 0; m_flags_left = 0; m_over = 0; m_won = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_click(1, 0, 1, 1, 1, 0, 1);
    settle();

    repeat (2) @(negedge clk);
    chk("sb_remaining", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
